// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Instruction memory width is shared with the fetch stage.
`timescale 1ns/1ps
package imem_loader_pkg;

  // Word-address width of instruction memory (depth = 2**IMEM_ADDR_W words).
  localparam int IMEM_ADDR_W = 10;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LEN_LO = 3'd1,
    LD_LEN_HI = 3'd2,
    LD_DATA   = 3'd3,
    LD_CHECK  = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERROR  = 3'd6
  } loader_state_e;

  // True in the states that consume bytes from the host link.
  function automatic logic loaderIsReceiving(input loader_state_e s);
    return (s == LD_LEN_LO) || (s == LD_LEN_HI) ||
           (s == LD_DATA)   || (s == LD_CHECK);
  endfunction

  // True in the states where a start pulse arms a new load.
  function automatic logic loaderCanStart(input loader_state_e s);
    return (s == LD_IDLE) || (s == LD_DONE) || (s == LD_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs incoming bytes little-endian into 32-bit words, keeps a running
// XOR checksum of every data byte, and pulses wordValid for one cycle
// after the fourth byte of a word has been taken.
`timescale 1ns/1ps
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  lane_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [7:0]  checksum_o
);

  logic [1:0]  laneQ;
  logic [23:0] partialQ;
  logic [31:0] wordQ;
  logic        wordValidQ;
  logic [7:0]  checksumQ;

  // Lane placement, word completion and checksum accumulation; the
  // completed word is held until the next word completes so the memory
  // data bus stays stable between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laneQ      <= 2'd0;
      partialQ   <= 24'd0;
      wordQ      <= 32'd0;
      wordValidQ <= 1'b0;
      checksumQ  <= 8'd0;
    end else if (clear_i) begin
      laneQ      <= 2'd0;
      partialQ   <= 24'd0;
      wordValidQ <= 1'b0;
      checksumQ  <= 8'd0;
    end else begin
      wordValidQ <= byte_valid_i && (laneQ == 2'd3);
      if (byte_valid_i) begin
        checksumQ <= checksumQ ^ byte_i;
        laneQ     <= laneQ + 2'd1;
        case (laneQ)
          2'd0:    partialQ[7:0]   <= byte_i;
          2'd1:    partialQ[15:8]  <= byte_i;
          2'd2:    partialQ[23:16] <= byte_i;
          default: wordQ           <= {byte_i, partialQ};
        endcase
      end
    end
  end

  assign lane_o       = laneQ;
  assign word_o       = wordQ;
  assign word_valid_o = wordValidQ;
  assign checksum_o   = checksumQ;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a length-prefixed, XOR-checked byte
// frame, writes the words to instruction memory from address 0 upward and
// keeps the processor in reset until a verified image is in place.
`timescale 1ns/1ps
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  // Largest legal word count: the image may fill memory exactly.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic              s_ready_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_error_q;
  logic [15:0]       len_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   word_cnt_next;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              accept;
  logic              arm;
  logic              data_byte;
  logic              word_done;
  logic              last_word;
  logic [15:0]       len_full;
  logic [1:0]        lane;
  logic [7:0]        checksum;
  logic [31:0]       asm_word;
  logic              asm_word_valid;

  assign accept        = s_valid && s_ready_q;
  assign arm           = start && loaderCanStart(state_q);
  assign data_byte     = accept && (state_q == LD_DATA);
  assign word_done     = data_byte && (lane == 2'd3);
  assign word_cnt_next = word_cnt_q + 1'b1;
  assign last_word     = (16'(word_cnt_next) == len_q);
  assign len_full      = {s_data, len_q[7:0]};

  imem_loader_word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (arm),
    .byte_valid_i (data_byte),
    .byte_i       (s_data),
    .lane_o       (lane),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid),
    .checksum_o   (checksum)
  );

  // Next-state selection for the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) state_d = LD_LEN_LO;
      end
      LD_LEN_LO: begin
        if (accept) state_d = LD_LEN_HI;
      end
      LD_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) state_d = LD_ERROR;
          else if (len_full == 16'd0)      state_d = LD_CHECK;
          else                              state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (word_done && last_word) state_d = LD_CHECK;
      end
      LD_CHECK: begin
        if (accept) state_d = (s_data == checksum) ? LD_DONE : LD_ERROR;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // State register, registered handshake/status outputs, length capture,
  // and the word counter that provides each write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LD_IDLE;
      s_ready_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      len_q        <= 16'd0;
      word_cnt_q   <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= loaderIsReceiving(state_d);
      cpu_hold_q   <= (state_d != LD_DONE);
      load_done_q  <= (state_d == LD_DONE);
      load_error_q <= (state_d == LD_ERROR);

      if (arm) begin
        word_cnt_q <= '0;
        len_q      <= 16'd0;
      end

      if (accept && (state_q == LD_LEN_LO)) len_q[7:0]  <= s_data;
      if (accept && (state_q == LD_LEN_HI)) len_q[15:8] <= s_data;

      if (word_done) begin
        mem_addr_q <= word_cnt_q[ADDR_W-1:0];
        word_cnt_q <= word_cnt_next;
      end
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = asm_word_valid;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = asm_word;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with hand-computed expectations.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = IMEM_ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  int vecCount = 0;
  int missCount = 0;
  int cyc = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int          lane3Cyc[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Cycle stamp, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(32'(mem_addr));
      wrData.push_back(mem_wdata);
      wrCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte and wait until it is accepted; returns the accept stamp.
  task automatic applyStimulus(input logic [7:0] b, output int accCyc);
    bit got;
    got = 1'b0;
    accCyc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      s_data  = b;
      s_valid = 1'b1;
      if (s_ready) begin
        @(posedge clk);
        #1;
        accCyc  = cyc;
        s_valid = 1'b0;
        got     = 1'b1;
      end
    end
    if (!got) begin
      s_valid = 1'b0;
      checkOutput("byteAcceptTimeout", {31'd0, got}, 32'd1);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int a;
    applyStimulus(b, a);
  endtask

  task automatic sendLen(input logic [15:0] n);
    sendByte(n[7:0]);
    sendByte(n[15:8]);
  endtask

  task automatic sendWord(input logic [31:0] w);
    int a;
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], a);
    lane3Cyc.push_back(a);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
    lane3Cyc.delete();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare logged writes against expected words at addresses 0..N-1.
  task automatic checkWrites(input string tag, input logic [31:0] exp[$]);
    checkOutput({tag, "_count"}, 32'(wrAddr.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], 32'(i));
      checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], exp[i]);
      if (i < lane3Cyc.size())
        checkOutput($sformatf("%s_lat%0d", tag, i), 32'(wrCyc[i]), 32'(lane3Cyc[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp[$];
    int bad;

    // Reset state.
    waitCycles(3);
    checkOutput("rst_s_ready",    32'(s_ready),    32'd0);
    checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
    checkOutput("rst_mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("rst_mem_wdata",  mem_wdata,       32'd0);
    checkOutput("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    checkOutput("rst_load_done",  32'(load_done),  32'd0);
    checkOutput("rst_load_error", 32'(load_error), 32'd0);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("idle_s_ready", 32'(s_ready), 32'd0);

    // Single word 0x12345678, checksum 0x08.
    clearLog();
    pulseStart();
    checkOutput("t1_s_ready_lenlo", 32'(s_ready), 32'd1);
    sendLen(16'd1);
    sendWord(32'h1234_5678);
    sendByte(8'h08);
    waitCycles(3);
    exp = '{32'h1234_5678};
    checkWrites("t1", exp);
    checkOutput("t1_done",       32'(load_done),  32'd1);
    checkOutput("t1_error",      32'(load_error), 32'd0);
    checkOutput("t1_cpu_hold",   32'(cpu_hold),   32'd0);
    checkOutput("t1_s_ready",    32'(s_ready),    32'd0);
    checkOutput("t1_we_idle",    32'(mem_we),     32'd0);
    checkOutput("t1_wdata_hold", mem_wdata,       32'h1234_5678);

    // Two words, streaming, checksum 0x23.
    clearLog();
    pulseStart();
    checkOutput("t2_cpu_hold_rearm", 32'(cpu_hold), 32'd1);
    sendLen(16'd2);
    sendWord(32'hDEAD_BEEF);
    sendWord(32'h0000_0001);
    sendByte(8'h23);
    waitCycles(3);
    exp = '{32'hDEAD_BEEF, 32'h0000_0001};
    checkWrites("t2", exp);
    checkOutput("t2_done",     32'(load_done), 32'd1);
    checkOutput("t2_cpu_hold", 32'(cpu_hold),  32'd0);

    // Same frame with a wrong checksum.
    clearLog();
    pulseStart();
    sendLen(16'd2);
    sendWord(32'hDEAD_BEEF);
    sendWord(32'h0000_0001);
    sendByte(8'h00);
    waitCycles(3);
    checkWrites("t3", exp);
    checkOutput("t3_error",    32'(load_error), 32'd1);
    checkOutput("t3_done",     32'(load_done),  32'd0);
    checkOutput("t3_cpu_hold", 32'(cpu_hold),   32'd1);
    checkOutput("t3_s_ready",  32'(s_ready),    32'd0);

    // Oversized length 1025 words.
    clearLog();
    pulseStart();
    sendLen(16'h0401);
    checkOutput("t4_error_now", 32'(load_error), 32'd1);
    checkOutput("t4_s_ready",   32'(s_ready),    32'd0);
    waitCycles(3);
    checkOutput("t4_writes",    32'(wrAddr.size()), 32'd0);
    checkOutput("t4_cpu_hold",  32'(cpu_hold),   32'd1);

    // Empty image: N=0, checksum 0x00.
    pulseStart();
    checkOutput("t4b_error_clr", 32'(load_error), 32'd0);
    sendLen(16'd0);
    sendByte(8'h00);
    waitCycles(3);
    checkOutput("t4b_done",     32'(load_done),     32'd1);
    checkOutput("t4b_writes",   32'(wrAddr.size()), 32'd0);
    checkOutput("t4b_cpu_hold", 32'(cpu_hold),      32'd0);

    // Reset after two bytes of a word.
    clearLog();
    pulseStart();
    sendLen(16'd1);
    sendByte(8'hAA);
    sendByte(8'hBB);
    rst = 1'b1;
    #1;
    checkOutput("t5_s_ready",    32'(s_ready),    32'd0);
    checkOutput("t5_mem_we",     32'(mem_we),     32'd0);
    checkOutput("t5_mem_addr",   32'(mem_addr),   32'd0);
    checkOutput("t5_mem_wdata",  mem_wdata,       32'd0);
    checkOutput("t5_cpu_hold",   32'(cpu_hold),   32'd1);
    checkOutput("t5_load_done",  32'(load_done),  32'd0);
    checkOutput("t5_load_error", 32'(load_error), 32'd0);
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("t5_writes", 32'(wrAddr.size()), 32'd0);
    clearLog();
    pulseStart();
    sendLen(16'd1);
    sendWord(32'hCAFE_F00D);
    sendByte(8'hC9);
    waitCycles(3);
    exp = '{32'hCAFE_F00D};
    checkWrites("t5b", exp);
    checkOutput("t5b_done", 32'(load_done), 32'd1);

    // Start pulsed mid-DATA is ignored.
    clearLog();
    pulseStart();
    sendLen(16'd1);
    sendByte(8'h11);
    sendByte(8'h22);
    pulseStart();
    sendByte(8'h33);
    sendByte(8'h44);
    sendByte(8'h44);
    waitCycles(3);
    checkOutput("t6_writes", 32'(wrAddr.size()), 32'd1);
    if (wrData.size() > 0) checkOutput("t6_data", wrData[0], 32'h4433_2211);
    checkOutput("t6_done", 32'(load_done), 32'd1);

    // Bytes offered in DONE are ignored.
    @(negedge clk);
    s_data  = 8'h55;
    s_valid = 1'b1;
    waitCycles(4);
    checkOutput("t6_done_s_ready", 32'(s_ready),   32'd0);
    checkOutput("t6_done_hold",    32'(load_done), 32'd1);
    s_valid = 1'b0;

    // Start from DONE re-arms with the processor held.
    clearLog();
    pulseStart();
    checkOutput("t7_cpu_hold", 32'(cpu_hold),  32'd1);
    checkOutput("t7_s_ready",  32'(s_ready),   32'd1);
    checkOutput("t7_done_clr", 32'(load_done), 32'd0);

    // Full-memory image, word i = i; checksum XORs out to 0x00.
    sendLen(16'd1024);
    for (int i = 0; i < 1024; i++) sendWord(32'(i));
    sendByte(8'h00);
    waitCycles(3);
    checkOutput("t8_count", 32'(wrAddr.size()), 32'd1024);
    bad = 0;
    for (int i = 0; i < wrAddr.size(); i++)
      if (wrAddr[i] !== 32'(i) || wrData[i] !== 32'(i) || wrCyc[i] != lane3Cyc[i]) bad++;
    checkOutput("t8_bad_writes", 32'(bad), 32'd0);
    if (wrAddr.size() == 1024) checkOutput("t8_last_addr", wrAddr[1023], 32'd1023);
    checkOutput("t8_done",     32'(load_done), 32'd1);
    checkOutput("t8_cpu_hold", 32'(cpu_hold),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction fetch stage.
- Receives a framed program image as a byte stream (valid/ready), assembles little-endian 32-bit words and writes them sequentially into instruction memory starting at word 0.
- Holds the processor in reset until a complete image has been written with a matching checksum.
- Sits between the host byte link (UART receiver or PS bridge) and the instruction memory write port.

Parameters:
- ADDR_W, 10, instruction memory word-address width; depth = 2**ADDR_W words (1024).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; arms a new load
- s_data  in  8  incoming byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  word address (byte address >> 2)
- mem_wdata  out  32  word to write
- cpu_hold  out  1  1 = processor held in reset
- load_done  out  1  level; image loaded and verified
- load_error  out  1  level; length overflow or checksum mismatch

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=0, state=IDLE.
- A byte is accepted only on a cycle where s_valid && s_ready.
- Frame format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - N x 4 data bytes, least significant byte first.
  - One checksum byte equal to the XOR of all 4N data bytes (length bytes excluded).
- State machine:
  - IDLE: s_ready=0. start -> LEN_LO. Clear word counter, byte index, checksum accumulator, load_done and load_error. Set cpu_hold=1.
  - LEN_LO: s_ready=1. On accept, latch N[7:0] -> LEN_HI.
  - LEN_HI: s_ready=1. On accept, latch N[15:8], then:
    - N > 2**ADDR_W -> ERROR.
    - N == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: s_ready=1.
    - On each accept, place the byte in lane byte_idx (0..3), XOR it into the checksum, and increment byte_idx modulo 4.
    - On acceptance of lane 3: the next cycle drives mem_we=1, mem_addr=word counter, mem_wdata=assembled word.
    - The word counter increments after each write.
    - After word N-1 is accepted -> CHECK.
  - CHECK: s_ready=1. On accept, a byte equal to the accumulator -> DONE; otherwise -> ERROR.
  - DONE: s_ready=0, load_done=1, cpu_hold=0. start -> LEN_LO (re-load; cpu_hold returns to 1 in the same cycle).
  - ERROR: s_ready=0, load_error=1, cpu_hold=1. start -> LEN_LO.
- Write latency: mem_we asserts exactly 1 cycle after the lane-3 byte is accepted. No backpressure is needed: a back-to-back byte may be accepted in the same cycle as the write.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- start outside IDLE/DONE/ERROR is ignored.
- s_valid in IDLE/DONE/ERROR is ignored; the byte is not consumed.
- N == 2**ADDR_W is legal and fills memory exactly; the word counter is ADDR_W+1 bits wide so the last address does not wrap.
- Words already written before an error remain in memory; cpu_hold stays 1.
- Reset mid-load aborts immediately:
  - In-flight partial word is discarded.
  - A pending mem_we is cleared.
  - cpu_hold=1.

Decomposition:
- Shared package contains:
  - loader state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - IMEM_ADDR_W=10, shared with instruction_fetch.
- One natural sub-module: word_assembler. It holds the byte lane index, 32-bit shift/lane register, XOR checksum and a word_valid pulse. The FSM owns addressing and the memory strobe.

Test Plan:
- Start; send 01 00 78 56 34 12 then checksum 0x08 -> single mem_we with addr 0, wdata 0x12345678; load_done=1; cpu_hold=0.
- Send N=2, words 0xDEADBEEF and 0x00000001 with s_valid every cycle -> mem_we at addr 0 then addr 1, each 1 cycle after its 4th byte; final state DONE.
- Same frame with checksum 0x00 -> both words written, load_error=1, load_done=0, cpu_hold=1.
- Send length 01 04 (N=1025) -> ERROR right after LEN_HI, no mem_we, s_ready=0. Send N=0 with checksum 0x00 -> DONE, no writes.
- Assert rst after 2 data bytes of a word -> all outputs at reset values at once, no mem_we. A following start plus a full valid frame loads correctly.
- Pulse start mid-DATA and drive s_valid in DONE -> no state change, no extra bytes consumed. Start in DONE -> cpu_hold=1 again and LEN_LO is entered.
